// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// access-size encodings, requester identifiers and the size-to-span helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Offset from the first to the last byte touched by an access of this size.
  function automatic logic [1:0] size_span(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_span = 2'd0;
      SZ_HALF: size_span = 2'd1;
      default: size_span = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of data grants made while a fetch is waiting; at_limit
// tells the arbiter to hand the next grant to the fetch side.
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one negedge-registered data memory between fetch (I) and
// load/store (D) requesters; one access every two cycles, D has priority.
//
// state | meaning
// IDLE  | no access in flight, waiting for a request
// ISSUE | command on M_*, memory acts at the mid-cycle negedge
// RESP  | RVALID pulse to the served requester; may issue the next access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic [1:0]        m_data_size,
  output logic              m_signed,
  input  logic [DATA_W-1:0] m_data_out
);

  arb_state_t state, state_nxt;
  req_id_t    owner;
  logic       cmd_we;
  logic       cmd_err;
  logic       at_limit;
  logic       issue_now;
  logic       pick_i;
  logic       pick_d;
  logic       d_bad;
  logic [ADDR_W:0] d_last;

  // Extra carry bit catches accesses whose last byte runs past the top address.
  assign d_last = {1'b0, d_addr} + {{(ADDR_W-1){1'b0}}, size_span(d_size)};
  assign d_bad  = (d_size == SZ_BAD) || d_last[ADDR_W];

  assign issue_now = (state != ISSUE) && (i_req || d_req);
  assign pick_i    = i_req && (!d_req || at_limit);
  assign pick_d    = d_req && !pick_i;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (issue_now && pick_d && i_req),
    .clr     ((issue_now && pick_i) || !i_req),
    .at_limit(at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = (i_req || d_req) ? ISSUE : IDLE;
      ISSUE:      state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_we  = 1'b0;
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (state == ISSUE) begin
      m_we  = cmd_we;
      i_gnt = (owner == REQ_I);
      d_gnt = (owner == REQ_D);
    end
  end

  // Rejected data accesses keep the previous address and present a word
  // read with write disabled, so the memory sees a harmless cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= REQ_I;
      cmd_we      <= 1'b0;
      cmd_err     <= 1'b0;
      m_addr      <= '0;
      m_data_in   <= '0;
      m_data_size <= 2'b00;
      m_signed    <= 1'b0;
    end else if (issue_now) begin
      if (pick_i) begin
        owner       <= REQ_I;
        cmd_we      <= 1'b0;
        cmd_err     <= 1'b0;
        m_addr      <= i_addr;
        m_data_in   <= '0;
        m_data_size <= SZ_WORD;
        m_signed    <= 1'b0;
      end else begin
        owner   <= REQ_D;
        cmd_err <= d_bad;
        if (d_bad) begin
          cmd_we      <= 1'b0;
          m_data_in   <= '0;
          m_data_size <= SZ_WORD;
          m_signed    <= 1'b0;
        end else begin
          cmd_we      <= d_we;
          m_addr      <= d_addr;
          m_data_in   <= d_wdata;
          m_data_size <= d_size;
          m_signed    <= d_signed;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      if (state == ISSUE) begin
        if (owner == REQ_I) begin
          i_rvalid <= 1'b1;
          i_rdata  <= m_data_out;
        end else begin
          d_rvalid <= 1'b1;
          d_err    <= cmd_err;
          d_rdata  <= (cmd_err || cmd_we) ? '0 : m_data_out;
        end
      end
    end
  end

endmodule
